// File: rtl/alu_vec_pkg.sv
// Shared types and constants for the ALU test-vector recorder.
// Holds the record layout, the mark codes and the recorder FSM state type.
package alu_vec_pkg;

    localparam int unsigned VEC_W = 120;

    localparam logic [3:0] MARK_SKIP = 4'h0;
    localparam logic [3:0] MARK_RUN  = 4'h1;
    localparam logic [3:0] MARK_END  = 4'h4;

    // MSB-to-LSB order matches the vector-checker file layout.
    typedef struct packed {
        logic [3:0]  mark;
        logic [15:0] index;
        logic [3:0]  op;
        logic [31:0] A;
        logic [31:0] B;
        logic [31:0] R;
    } alu_vec_t;

    typedef enum logic [1:0] {
        StRec,
        StTerm,
        StDone
    } rec_state_e;

endpackage

// File: rtl/vec_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports: clk/rst (sync, active-high); push/push_data/full on the write side;
// pop/pop_data/empty on the read side; count = entries currently held.
// A push is accepted only when the FIFO was not full at the start of the cycle,
// even if a pop happens in the same cycle.
module vec_fifo #(
    parameter int unsigned WIDTH = 120,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr_q];
    assign count    = count_q;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/alu_vec_recorder.sv
// Observes ALU transactions and packs each into a 120-bit vector record,
// buffering records in a FWFT FIFO drained over a ready/valid port.
// Ports: clk, rst (sync, active-high); in_valid/in_op/in_A/in_B/in_R observed
// ALU transaction; finish closes the trace with a terminator record;
// out_valid/out_ready/out_vector drain port; count buffered records;
// overflow sticky drop flag; done terminator emitted and FIFO empty.
module alu_vec_recorder #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       in_op,
    input  logic [31:0]      in_A,
    input  logic [31:0]      in_B,
    input  logic [31:0]      in_R,
    input  logic             finish,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [119:0]     out_vector,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             done
);

    import alu_vec_pkg::*;

    rec_state_e state_q, state_d;
    logic [15:0] idx_q, idx_d;
    logic        overflow_q, overflow_d;
    logic        push;
    alu_vec_t    push_rec;
    logic        fifo_full;
    logic        fifo_empty;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        overflow_d = overflow_q;
        push       = 1'b0;
        push_rec   = '{mark: MARK_RUN, index: idx_q, op: in_op, A: in_A, B: in_B, R: in_R};
        unique case (state_q)
            StRec: begin
                // A transaction alongside finish is still recorded.
                if (in_valid) begin
                    if (fifo_full) begin
                        overflow_d = 1'b1;
                    end else begin
                        push  = 1'b1;
                        idx_d = idx_q + 16'd1;
                    end
                end
                if (finish) begin
                    state_d = StTerm;
                end
            end
            StTerm: begin
                push_rec       = '0;
                push_rec.mark  = MARK_END;
                push_rec.index = idx_q;
                // Wait for space rather than dropping the terminator.
                if (!fifo_full) begin
                    push    = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
            end
            default: state_d = StRec;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StRec;
            idx_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
        end
    end

    vec_fifo #(
        .WIDTH (VEC_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_rec),
        .full      (fifo_full),
        .pop       (out_ready),
        .pop_data  (out_vector),
        .empty     (fifo_empty),
        .count     (count)
    );

    assign out_valid = !fifo_empty;
    assign overflow  = overflow_q;
    assign done      = (state_q == StDone) && (count == '0);

endmodule

// File: tb/tb_alu_vec_recorder.sv
module tb_alu_vec_recorder;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [3:0]       in_op = '0;
    logic [31:0]      in_A = '0;
    logic [31:0]      in_B = '0;
    logic [31:0]      in_R = '0;
    logic             finish = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [119:0]     out_vector;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             done;

    int n_checks = 0;
    int n_fail = 0;
    logic [119:0] exp_q [$];
    logic [15:0]  exp_idx = '0;

    alu_vec_recorder #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_op      (in_op),
        .in_A       (in_A),
        .in_B       (in_B),
        .in_R       (in_R),
        .finish     (finish),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_vector (out_vector),
        .count      (count),
        .overflow   (overflow),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [119:0] act, input logic [119:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        finish   = 1'b0;
    endtask

    // Drive one transaction for one cycle; queue its record if it should be kept.
    task automatic txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input bit accept);
        in_valid = 1'b1;
        in_op = op;
        in_A = a;
        in_B = b;
        in_R = r;
        if (accept) begin
            exp_q.push_back({4'h1, exp_idx, op, a, b, r});
            exp_idx = exp_idx + 16'd1;
        end
        sync();
    endtask

    task automatic do_reset();
        out_ready = 1'b0;
        idle();
        rst = 1'b1;
        exp_q.delete();
        exp_idx = '0;
        sync();
        rst = 1'b0;
        @(negedge clk);
        check("reset out_valid", 120'(out_valid), 120'(1'b0));
        check("reset count", 120'(count), 120'(0));
        check("reset overflow", 120'(overflow), 120'(1'b0));
        check("reset done", 120'(done), 120'(1'b0));
        sync();
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        out_ready = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while ((out_valid || exp_q.size() != 0) && n < budget);
        if (out_valid || exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain timeout: out_valid=%0b pending=%0d", out_valid, exp_q.size());
        end
        sync();
    endtask

    // Monitor: pops the scoreboard on every handshake and checks hold stability.
    initial begin : monitor
        logic [119:0] held;
        logic [119:0] exp;
        bit hold_valid;
        hold_valid = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (hold_valid) begin
                    check("stable while stalled", out_vector, held);
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected record: got %h, expected none", out_vector);
                    end else begin
                        exp = exp_q.pop_front();
                        check("record", out_vector, exp);
                    end
                    hold_valid = 1'b0;
                end else begin
                    hold_valid = 1'b1;
                    held = out_vector;
                end
            end else begin
                hold_valid = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        sync();
        do_reset();

        // Single transaction, first-word-fall-through visibility.
        txn(4'h2, 32'h5, 32'h3, 32'h8, 1'b1);
        idle();
        @(negedge clk);
        check("first out_valid", 120'(out_valid), 120'(1'b1));
        check("first vector", out_vector, 120'h1_0000_2_00000005_00000003_00000008);
        check("first count", 120'(count), 120'(1));
        sync();
        wait_drain(50);

        // Overflow: 17 transactions into a 16-entry FIFO with no consumer.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            txn(4'(i), 32'h100 + 32'(i), 32'h200 + 32'(i), 32'h300 + 32'(i), i < 16);
        end
        idle();
        @(negedge clk);
        check("full count", 120'(count), 120'(16));
        check("overflow set", 120'(overflow), 120'(1'b1));
        sync();
        wait_drain(100);
        @(negedge clk);
        check("overflow sticky", 120'(overflow), 120'(1'b1));
        check("drained count", 120'(count), 120'(0));
        sync();

        // Three transactions then finish, consumer always ready.
        do_reset();
        out_ready = 1'b1;
        txn(4'h1, 32'hA, 32'hB, 32'hC, 1'b1);
        txn(4'h3, 32'hDEAD_BEEF, 32'h1, 32'hDEAD_BEF0, 1'b1);
        txn(4'hF, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1);
        idle();
        finish = 1'b1;
        exp_q.push_back({4'h4, 16'h0003, 100'h0});
        sync();
        idle();
        wait_drain(50);
        @(negedge clk);
        check("done after drain", 120'(done), 120'(1'b1));
        sync();
        for (int i = 0; i < 4; i++) begin
            txn(4'h5, 32'(i), 32'(i), 32'(i), 1'b0);
        end
        finish = 1'b1;
        sync();
        idle();
        @(negedge clk);
        check("done ignores in_valid", 120'(count), 120'(0));
        check("done stays", 120'(done), 120'(1'b1));
        sync();

        // finish together with a transaction.
        do_reset();
        out_ready = 1'b1;
        finish = 1'b1;
        txn(4'h7, 32'h11, 32'h22, 32'h33, 1'b1);
        idle();
        exp_q.push_back({4'h4, 16'h0001, 100'h0});
        wait_drain(50);
        @(negedge clk);
        check("done after same-cycle finish", 120'(done), 120'(1'b1));
        sync();

        // FIFO full at finish: terminator waits in TERM for space.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            txn(4'h9, 32'(i), 32'(i * 2), 32'(i * 3), 1'b1);
        end
        idle();
        finish = 1'b1;
        exp_q.push_back({4'h4, 16'h0010, 100'h0});
        sync();
        idle();
        sync();
        sync();
        @(negedge clk);
        check("term held count", 120'(count), 120'(16));
        check("term held done", 120'(done), 120'(1'b0));
        check("term no overflow", 120'(overflow), 120'(1'b0));
        sync();
        out_ready = 1'b1;
        sync();
        out_ready = 1'b0;
        @(negedge clk);
        check("after pop count", 120'(count), 120'(15));
        sync();
        @(negedge clk);
        check("term pushed count", 120'(count), 120'(16));
        sync();
        wait_drain(100);
        @(negedge clk);
        check("done after full term", 120'(done), 120'(1'b1));
        sync();

        // Index wrap: 65535 streamed transactions, then two more.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            txn(4'(i), 32'(i), ~32'(i), 32'(i) + 32'd1, 1'b1);
        end
        in_valid = 1'b1;
        in_op = 4'hC;
        in_A = 32'h1234_5678;
        in_B = 32'h0000_0001;
        in_R = 32'h1234_5679;
        exp_q.push_back(120'h1_FFFF_C_12345678_00000001_12345679);
        sync();
        in_op = 4'hD;
        in_A = 32'h8000_0000;
        in_B = 32'h8000_0000;
        in_R = 32'h0000_0000;
        exp_q.push_back(120'h1_0000_D_80000000_80000000_00000000);
        sync();
        idle();
        wait_drain(100);

        // Reset with records buffered.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            txn(4'h6, 32'(i), 32'(i), 32'(i), 1'b1);
        end
        txn(4'h6, 32'h0, 32'h0, 32'h0, 1'b1);
        idle();
        @(negedge clk);
        check("buffered count", 120'(count), 120'(6));
        sync();
        do_reset();
        out_ready = 1'b1;
        txn(4'hA, 32'h77, 32'h88, 32'hFF, 1'b0);
        exp_q.push_back(120'h1_0000_A_00000077_00000088_000000FF);
        idle();
        wait_drain(50);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
